proto245_cmd_bridge: RTL and testbench

Command decoder/responder downstream of the FT245 master's RX FIFO read port and upstream of its TX FIFO write port. It parses a byte stream from the host into single-word register reads and writes on a simple memory-mapped bus. Read data is returned byte-serially into the TX FIFO. The block runs in the FIFO (system) clock domain.

---
 rtl/proto245_cmd_pkg.sv | 22 ++
 rtl/proto245_byte_fetch.sv | 38 +++
 rtl/proto245_cmd_bridge.sv | 187 ++++++++++++++++++
 tb/tb_proto245_cmd_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proto245_cmd_pkg.sv
// proto245_cmd_pkg: shared state encoding and protocol byte constants
// for the FT245 command bridge. Optional macro: PROTO245_CMD_BRIDGE_WRACK_EN.
package proto245_cmd_pkg;

    localparam logic [7:0] CMD_WR    = 8'hA5;
    localparam logic [7:0] CMD_RD    = 8'h5A;
    localparam logic [7:0] RSP_WRACK = 8'hAC;
    localparam logic [7:0] RSP_WRERR = 8'hEE;

    typedef enum logic [2:0] {
        CMD_S,
        ADDR_S,
        DATA_S,
        BUS_S,
        RESP_S
`ifdef PROTO245_CMD_BRIDGE_WRACK_EN
        ,
        ACK_S
`endif
    } state_t;

endpackage

// File: rtl/proto245_byte_fetch.sv
// proto245_byte_fetch: one-outstanding RX FIFO read handshake.
// Ports: clk/rst, req (consumer wants bytes), rxfifo_* FIFO side,
// byte_o/byte_vld one-cycle byte strobe to the consumer.
module proto245_byte_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rxfifo_empty,
    input  logic       rxfifo_valid,
    input  logic [7:0] rxfifo_data,
    output logic       rxfifo_rd,
    output logic [7:0] byte_o,
    output logic       byte_vld
);

    logic pend_q;
    logic run_q;

    // run_q keeps the strobe low while reset is (or just was) asserted
    assign rxfifo_rd = req & run_q & ~rxfifo_empty & ~pend_q;
    // a valid with no read outstanding is dropped here
    assign byte_vld  = rxfifo_valid & pend_q;
    assign byte_o    = rxfifo_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (rxfifo_rd)
                pend_q <= 1'b1;
            else if (byte_vld)
                pend_q <= 1'b0;
        end
    end

endmodule

// File: rtl/proto245_cmd_bridge.sv
// proto245_cmd_bridge: decodes host byte frames into mm bus reads/writes
// and returns read data byte-serially. Optional macro: PROTO245_CMD_BRIDGE_WRACK_EN.
// Ports: clk/rst; rxfifo_* RX read side; txfifo_* TX write side;
// mm_* single-word bus master; timeout_err pulse on abandoned access.
module proto245_cmd_bridge
    import proto245_cmd_pkg::*;
#(
    parameter int ADDR_BYTES    = 2,
    parameter int DATA_BYTES    = 4,
    parameter int TIMEOUT_TICKS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rxfifo_rd,
    input  logic [7:0]              rxfifo_data,
    input  logic                    rxfifo_valid,
    input  logic                    rxfifo_empty,
    output logic [7:0]              txfifo_data,
    output logic                    txfifo_wr,
    input  logic                    txfifo_full,
    output logic [8*ADDR_BYTES-1:0] mm_addr,
    output logic [8*DATA_BYTES-1:0] mm_wdata,
    output logic                    mm_wr,
    output logic                    mm_rd,
    input  logic [8*DATA_BYTES-1:0] mm_rdata,
    input  logic                    mm_ack,
    output logic                    timeout_err
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int CW    = 3;
    localparam int TW    = $clog2(TIMEOUT_TICKS + 1);
    localparam int CMAXI = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CMAXI);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_adv;
    logic            is_wr;
    logic [DW-1:0]   resp;
    logic [DW-1:0]   resp_sh;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            fetch_req;
    logic [7:0]      rx_byte;
    logic            bv;

    proto245_byte_fetch u_fetch (
        .clk          (clk),
        .rst          (rst),
        .req          (fetch_req),
        .rxfifo_empty (rxfifo_empty),
        .rxfifo_valid (rxfifo_valid),
        .rxfifo_data  (rxfifo_data),
        .rxfifo_rd    (rxfifo_rd),
        .byte_o       (rx_byte),
        .byte_vld     (bv)
    );

    assign resp_sh = resp >> {cnt, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= CMD_S;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        fetch_req   = 1'b0;
        cnt_adv     = 1'b0;
        txfifo_wr   = 1'b0;
        txfifo_data = 8'h00;
        tmo_hit     = 1'b0;
        unique case (state)
            CMD_S: begin
                fetch_req = 1'b1;
                if (bv && (rx_byte == CMD_WR || rx_byte == CMD_RD))
                    state_nxt = ADDR_S;
            end
            ADDR_S: begin
                fetch_req = 1'b1;
                cnt_adv   = bv;
                if (bv && cnt == ADDR_LAST)
                    state_nxt = is_wr ? DATA_S : BUS_S;
            end
            DATA_S: begin
                fetch_req = 1'b1;
                cnt_adv   = bv;
                if (bv && cnt == DATA_LAST)
                    state_nxt = BUS_S;
            end
            BUS_S: begin
                // ack on the final tick wins over the timeout
                tmo_hit = !mm_ack && tmo_cnt == TMO_LAST;
                if (mm_ack || tmo_hit) begin
                    if (!is_wr)
                        state_nxt = RESP_S;
                    else
`ifdef PROTO245_CMD_BRIDGE_WRACK_EN
                        state_nxt = ACK_S;
`else
                        state_nxt = CMD_S;
`endif
                end
            end
            RESP_S: begin
                txfifo_wr   = !txfifo_full;
                txfifo_data = resp_sh[7:0];
                cnt_adv     = !txfifo_full;
                if (!txfifo_full && cnt == DATA_LAST)
                    state_nxt = CMD_S;
            end
`ifdef PROTO245_CMD_BRIDGE_WRACK_EN
            ACK_S: begin
                txfifo_wr   = !txfifo_full;
                txfifo_data = resp[7:0];
                if (!txfifo_full)
                    state_nxt = CMD_S;
            end
`endif
            default: state_nxt = CMD_S;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            is_wr       <= 1'b0;
            mm_addr     <= '0;
            mm_wdata    <= '0;
            mm_wr       <= 1'b0;
            mm_rd       <= 1'b0;
            resp        <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;

            if (state_nxt != state)
                cnt <= '0;
            else if (cnt_adv && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (state == CMD_S && bv)
                is_wr <= (rx_byte == CMD_WR);

            if (state == ADDR_S && bv)
                for (int i = 0; i < ADDR_BYTES; i++)
                    if (cnt == CW'(i))
                        mm_addr[8*i +: 8] <= rx_byte;

            if (state == DATA_S && bv)
                for (int i = 0; i < DATA_BYTES; i++)
                    if (cnt == CW'(i))
                        mm_wdata[8*i +: 8] <= rx_byte;

            // request rises the cycle after the final frame byte
            if (state != BUS_S && state_nxt == BUS_S) begin
                mm_wr <= is_wr;
                mm_rd <= !is_wr;
            end

            if (state == BUS_S) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (mm_ack || tmo_hit) begin
                    mm_wr <= 1'b0;
                    mm_rd <= 1'b0;
                    if (!is_wr)
                        resp <= mm_ack ? mm_rdata : '1;
`ifdef PROTO245_CMD_BRIDGE_WRACK_EN
                    else
                        resp <= DW'(mm_ack ? RSP_WRACK : RSP_WRERR);
`endif
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_proto245_cmd_bridge.sv
// tb_proto245_cmd_bridge: FIFO/bus environment with a frame-level model;
// directed frames from the test plan plus randomized frames.
module tb_proto245_cmd_bridge;
    import proto245_cmd_pkg::*;

    localparam int AB  = 2;
    localparam int DB  = 4;
    localparam int TMO = 256;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } rxb_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } bus_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        rxfifo_rd;
    logic [7:0]  rxfifo_data = 0;
    logic        rxfifo_valid = 0;
    logic        rxfifo_empty = 1;
    logic [7:0]  txfifo_data;
    logic        txfifo_wr;
    logic        txfifo_full = 0;
    logic [15:0] mm_addr;
    logic [31:0] mm_wdata;
    logic        mm_wr;
    logic        mm_rd;
    logic [31:0] mm_rdata = 0;
    logic        mm_ack = 0;
    logic        timeout_err;

    proto245_cmd_bridge #(
        .ADDR_BYTES    (AB),
        .DATA_BYTES    (DB),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxfifo_rd    (rxfifo_rd),
        .rxfifo_data  (rxfifo_data),
        .rxfifo_valid (rxfifo_valid),
        .rxfifo_empty (rxfifo_empty),
        .txfifo_data  (txfifo_data),
        .txfifo_wr    (txfifo_wr),
        .txfifo_full  (txfifo_full),
        .mm_addr      (mm_addr),
        .mm_wdata     (mm_wdata),
        .mm_wr        (mm_wr),
        .mm_rd        (mm_rd),
        .mm_rdata     (mm_rdata),
        .mm_ack       (mm_ack),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;

    rxb_t       rx_q[$];
    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];

    bit   force_full = 0;
    bit   rx_pend = 0;
    rxb_t pend_b;
    bit   rd_prev = 0;
    bit   req_prev = 0;
    bit   real_vld = 0;
    bit   vld_last = 0;
    bit   lastwr_prev = 0;
    bit   exp_te = 0;
    bit   cur_ok = 0;
    bus_t cur;
    int   hi = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic push_byte(logic [7:0] b, bit last);
        rxb_t e;
        e.b    = b;
        e.last = last;
        rx_q.push_back(e);
    endtask

    task automatic push_word_tx(logic [31:0] w);
        for (int i = 0; i < DB; i++)
            exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic exp_wr_rsp(bit acked);
`ifdef PROTO245_CMD_BRIDGE_WRACK_EN
        exp_tx.push_back(acked ? RSP_WRACK : RSP_WRERR);
`else
        if (acked) begin end
`endif
    endtask

    task automatic push_exp(bit wr, logic [15:0] a, logic [31:0] d,
                            int dly, logic [31:0] rdv);
        bus_t r;
        r.wr = wr;
        r.addr = a;
        r.wdata = d;
        r.delay = dly;
        r.rdata = rdv;
        exp_bus.push_back(r);
        if (wr)
            exp_wr_rsp(dly > 0);
        else
            push_word_tx(dly > 0 ? rdv : 32'hFFFF_FFFF);
    endtask

    task automatic send_frame(bit wr, logic [15:0] a, logic [31:0] d,
                              int dly, logic [31:0] rdv, int ng);
        logic [7:0] g;
        for (int i = 0; i < ng; i++) begin
            do g = 8'($urandom);
            while (g == CMD_WR || g == CMD_RD);
            push_byte(g, 0);
        end
        push_byte(wr ? CMD_WR : CMD_RD, 0);
        for (int i = 0; i < AB; i++)
            push_byte(a[8*i +: 8], 0);
        if (wr)
            for (int i = 0; i < DB; i++)
                push_byte(d[8*i +: 8], i == DB - 1);
        push_exp(wr, a, d, dly, rdv);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (!(rx_q.size() == 0 && !rx_pend && exp_bus.size() == 0 &&
                 exp_tx.size() == 0 && !req_prev) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            fail("idle_budget_expired");
            rx_q.delete();
            exp_bus.delete();
            exp_tx.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // FIFO/bus environment and per-cycle compare
    always @(negedge clk) begin
        if (rst) begin
            rxfifo_valid = 0;
            rxfifo_empty = 1;
            txfifo_full  = 0;
            mm_ack       = 0;
            mm_rdata     = 0;
            rx_pend      = 0;
            rd_prev      = 0;
            req_prev     = 0;
            lastwr_prev  = 0;
            cur_ok       = 0;
            hi           = 0;
        end else begin
            real_vld     = 0;
            vld_last     = 0;
            rxfifo_valid = 0;
            rxfifo_data  = 8'($urandom);
            if (rx_pend) begin
                rxfifo_valid = 1;
                rxfifo_data  = pend_b.b;
                vld_last     = pend_b.last;
                real_vld     = 1;
                rx_pend      = 0;
            end else if (!rd_prev && $urandom_range(0, 9) == 0) begin
                rxfifo_valid = 1;
            end
            mm_ack   = 0;
            mm_rdata = $urandom;
            if (req_prev && cur_ok && cur.delay > 0 && hi == cur.delay) begin
                mm_ack   = 1;
                mm_rdata = cur.rdata;
            end
            txfifo_full  = force_full || ($urandom_range(0, 3) == 0);
            rxfifo_empty = (rx_q.size() == 0) || ($urandom_range(0, 4) == 0);
            #1;
            exp_te = 0;
            if (lastwr_prev)
                chk("wr_latency", 64'(mm_wr), 1);
            if (rxfifo_rd) begin
                chk("rd_while_empty", 64'(rxfifo_empty), 0);
                chk("rd_outstanding", 64'(rd_prev | real_vld), 0);
                if (rx_q.size() > 0) begin
                    pend_b  = rx_q.pop_front();
                    rx_pend = 1;
                end
            end
            chk("wr_rd_exclusive", 64'(mm_wr & mm_rd), 0);
            if ((mm_wr | mm_rd) && !req_prev) begin
                hi = 0;
                if (exp_bus.size() == 0) begin
                    fail("unexpected_request");
                    cur_ok = 0;
                end else begin
                    cur    = exp_bus.pop_front();
                    cur_ok = 1;
                    chk("bus_dir", 64'(mm_wr), 64'(cur.wr));
                    chk("bus_addr", 64'(mm_addr), 64'(cur.addr));
                    if (cur.wr)
                        chk("bus_wdata", 64'(mm_wdata), 64'(cur.wdata));
                end
            end else if ((mm_wr | mm_rd) && cur_ok) begin
                chk("addr_stable", 64'(mm_addr), 64'(cur.addr));
                if (cur.wr)
                    chk("wdata_stable", 64'(mm_wdata), 64'(cur.wdata));
            end
            if (mm_wr | mm_rd)
                hi++;
            if (!(mm_wr | mm_rd) && req_prev && cur_ok) begin
                if (cur.delay > 0) begin
                    chk("req_len_ack", 64'(hi), 64'(cur.delay + 1));
                end else begin
                    chk("req_len_timeout", 64'(hi), 64'(TMO));
                    exp_te = 1;
                end
                cur_ok = 0;
            end
            chk("timeout_err", 64'(timeout_err), 64'(exp_te));
            if (txfifo_wr) begin
                chk("tx_while_full", 64'(txfifo_full), 0);
                if (!txfifo_full) begin
                    if (exp_tx.size() == 0)
                        fail("tx_unexpected");
                    else
                        chk("tx_byte", 64'(txfifo_data), 64'(exp_tx.pop_front()));
                end
            end
            rd_prev     = rxfifo_rd;
            req_prev    = mm_wr | mm_rd;
            lastwr_prev = vld_last;
        end
    end

    initial begin
        int k;
        bit wr;
        int dly;
        #3;
        chk("rst_rd", 64'(rxfifo_rd), 0);
        chk("rst_outs", {mm_addr, mm_wdata, txfifo_data},  0);
        chk("rst_strobes", {txfifo_wr, mm_wr, mm_rd, timeout_err}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 0;

        // write, ack after 3 clk
        push_byte(8'hA5, 0);
        push_byte(8'h34, 0);
        push_byte(8'h12, 0);
        push_byte(8'h78, 0);
        push_byte(8'h56, 0);
        push_byte(8'h34, 0);
        push_byte(8'h12, 1);
        push_exp(1, 16'h1234, 32'h1234_5678, 3, 0);
        wait_idle(500);

        // read returning DEADBEEF
        push_byte(8'h5A, 0);
        push_byte(8'h10, 0);
        push_byte(8'h00, 0);
        begin
            bus_t r;
            r.wr = 0;
            r.addr = 16'h0010;
            r.wdata = 0;
            r.delay = 2;
            r.rdata = 32'hDEAD_BEEF;
            exp_bus.push_back(r);
        end
        exp_tx.push_back(8'hEF);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hAD);
        exp_tx.push_back(8'hDE);
        wait_idle(500);

        // read with no ack
        send_frame(0, 16'h0BAD, 0, 0, 0, 0);
        wait_idle(1000);

        // garbage bytes then read under TX backpressure
        force_full = 1;
        push_byte(8'h00, 0);
        push_byte(8'hFF, 0);
        push_byte(8'h5A, 0);
        push_byte(8'h01, 0);
        push_byte(8'h00, 0);
        push_exp(0, 16'h0001, 0, 4, 32'hCAFE_0123);
        k = 0;
        while ((exp_bus.size() != 0 || req_prev) && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400)
            fail("garbage_read_budget");
        repeat (20) @(negedge clk);
        chk("full_hold_tx_pending", 64'(exp_tx.size()), 4);
        force_full = 0;
        wait_idle(500);

        // reset in the middle of a frame
        push_byte(CMD_WR, 0);
        push_byte(8'h34, 0);
        k = 0;
        while ((rx_q.size() != 0 || rx_pend) && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_addr", 64'(mm_addr), 0);
        chk("midrst_strobes", {rxfifo_rd, txfifo_wr, mm_wr, mm_rd, timeout_err}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 0;
        push_byte(8'h5A, 0);
        push_byte(8'h02, 0);
        push_byte(8'h00, 0);
        push_exp(0, 16'h0002, 0, 1, 32'h0102_0304);
        wait_idle(500);

        // write that times out
        send_frame(1, 16'hBEEF, 32'h0BAD_F00D, 0, 0, 1);
        wait_idle(1000);

        // randomized frames
        for (int n = 0; n < 30; n++) begin
            wr  = $urandom_range(0, 1) == 1;
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            send_frame(wr, 16'($urandom), $urandom, dly, $urandom,
                       int'($urandom_range(0, 2)));
        end
        wait_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
